// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID/EX operand stage.
package cpu_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned CTRL_W_DEF = 16;

  localparam logic [REG_AW-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Last instruction handed to EX, kept for MEM/WB forwarding tags.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
  } hist_t;

  // A producer feeds a source only when it really writes that register; XZR never forwards.
  function automatic logic prod_match(input logic              valid,
                                      input logic              reg_write,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] rs);
    return valid && reg_write && (rd == rs) && (rs != XZR);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand priority select: output register > history > MEM port > WB port > regfile.
// WB_BYPASS_EN: when defined, a WB match bypasses wb data instead of stalling.
module operand_fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] i_rs,
  input  logic [XLEN-1:0]   i_rf_data,
  input  logic              i_a_valid,
  input  logic [REG_AW-1:0] i_a_rd,
  input  logic              i_a_reg_write,
  input  logic              i_a_mem_read,
  input  logic              i_b_valid,
  input  logic [REG_AW-1:0] i_b_rd,
  input  logic              i_b_reg_write,
  input  logic              i_c_valid,
  input  logic [REG_AW-1:0] i_c_rd,
  input  logic [XLEN-1:0]   i_c_data,
  input  logic              i_d_valid,
  input  logic [REG_AW-1:0] i_d_rd,
`ifdef WB_BYPASS_EN
  input  logic [XLEN-1:0]   i_d_data,
`endif
  output logic [XLEN-1:0]   o_op,
  output fwd_sel_e          o_tag,
  output logic              o_hazard
);

  always_comb begin
    o_op     = i_rf_data;
    o_tag    = FWD_NONE;
    o_hazard = 1'b0;
    if (i_rs == XZR) begin
      o_op = '0;
    end else if (prod_match(i_a_valid, i_a_reg_write, i_a_rd, i_rs)) begin
      // A load in the output register has no data yet: hold decode for one bubble.
      if (i_a_mem_read) begin
        o_hazard = 1'b1;
      end else begin
        o_tag = FWD_EXMEM;
      end
    end else if (prod_match(i_b_valid, i_b_reg_write, i_b_rd, i_rs)) begin
      o_tag = FWD_MEMWB;
    end else if (prod_match(i_c_valid, 1'b1, i_c_rd, i_rs)) begin
      o_op = i_c_data;
    end else if (prod_match(i_d_valid, 1'b1, i_d_rd, i_rs)) begin
`ifdef WB_BYPASS_EN
      o_op = i_d_data;
`else
      o_hazard = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves source operands and forwarding tags, registers them toward EX.
// WB_BYPASS_EN: when defined, same-edge WB writes are bypassed; otherwise they cost one stall.
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [XLEN-1:0]   rf_data1,
  input  logic [XLEN-1:0]   rf_data2,
  input  logic              mem_fwd_valid,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output fwd_sel_e          out_fwd1,
  output fwd_sel_e          out_fwd2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              r_valid;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  fwd_sel_e          r_fwd1;
  fwd_sel_e          r_fwd2;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic [CTRL_W-1:0] r_ctrl;
  hist_t             r_hist;

  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  fwd_sel_e          w_tag1;
  fwd_sel_e          w_tag2;
  logic              w_hz1;
  logic              w_hz2;
  logic              w_hazard;
  logic              w_in_ready;
  logic              w_accept;

`ifndef WB_BYPASS_EN
  logic              w_unused_wb;
  assign w_unused_wb = ^wb_data;
`endif

  operand_fwd_mux u_fwd1 (
    .i_rs          (in_rs1),
    .i_rf_data     (rf_data1),
    .i_a_valid     (r_valid),
    .i_a_rd        (r_rd),
    .i_a_reg_write (r_reg_write),
    .i_a_mem_read  (r_mem_read),
    .i_b_valid     (r_hist.valid),
    .i_b_rd        (r_hist.rd),
    .i_b_reg_write (r_hist.reg_write),
    .i_c_valid     (mem_fwd_valid),
    .i_c_rd        (mem_fwd_rd),
    .i_c_data      (mem_fwd_data),
    .i_d_valid     (wb_valid),
    .i_d_rd        (wb_rd),
`ifdef WB_BYPASS_EN
    .i_d_data      (wb_data),
`endif
    .o_op          (w_op1),
    .o_tag         (w_tag1),
    .o_hazard      (w_hz1)
  );

  operand_fwd_mux u_fwd2 (
    .i_rs          (in_rs2),
    .i_rf_data     (rf_data2),
    .i_a_valid     (r_valid),
    .i_a_rd        (r_rd),
    .i_a_reg_write (r_reg_write),
    .i_a_mem_read  (r_mem_read),
    .i_b_valid     (r_hist.valid),
    .i_b_rd        (r_hist.rd),
    .i_b_reg_write (r_hist.reg_write),
    .i_c_valid     (mem_fwd_valid),
    .i_c_rd        (mem_fwd_rd),
    .i_c_data      (mem_fwd_data),
    .i_d_valid     (wb_valid),
    .i_d_rd        (wb_rd),
`ifdef WB_BYPASS_EN
    .i_d_data      (wb_data),
`endif
    .o_op          (w_op2),
    .o_tag         (w_tag2),
    .o_hazard      (w_hz2)
  );

  assign w_hazard   = w_hz1 | w_hz2;
  assign w_in_ready = (!r_valid || out_ready) && !w_hazard;
  assign w_accept   = in_valid && w_in_ready && !flush;

  // Output register: bubble on fire without accept, hold while EX back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_fwd1      <= FWD_NONE;
      r_fwd2      <= FWD_NONE;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_ctrl      <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_op1       <= w_op1;
        r_op2       <= w_op2;
        r_fwd1      <= w_tag1;
        r_fwd2      <= w_tag2;
        r_rd        <= in_rd;
        r_reg_write <= in_reg_write;
        r_mem_read  <= in_mem_read;
        r_ctrl      <= in_ctrl;
      end
    end
  end

  // History follows the output register whenever EX advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (out_ready) begin
      r_hist.valid     <= r_valid;
      r_hist.rd        <= r_rd;
      r_hist.reg_write <= r_reg_write;
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = r_valid;
  assign out_op1       = r_op1;
  assign out_op2       = r_op2;
  assign out_fwd1      = r_fwd1;
  assign out_fwd2      = r_fwd2;
  assign out_rd        = r_rd;
  assign out_reg_write = r_reg_write;
  assign out_mem_read  = r_mem_read;
  assign out_ctrl      = r_ctrl;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed hazard scenarios plus random traffic vs a reference model.
module tb_id_ex_operand_stage;
  import cpu_pkg::*;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rs1, in_rs2, in_rd;
  logic          in_reg_write, in_mem_read;
  logic [CW-1:0] in_ctrl;
  logic [63:0]   rf_data1, rf_data2;
  logic          mem_fwd_valid;
  logic [4:0]    mem_fwd_rd;
  logic [63:0]   mem_fwd_data;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic [63:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_op1, out_op2;
  logic [1:0]    out_fwd1, out_fwd2;
  logic [4:0]    out_rd;
  logic          out_reg_write, out_mem_read;
  logic [CW-1:0] out_ctrl;

  // Behavioural register file; X31 entry is never written so it reads zero.
  logic [63:0] regs [32];
  assign rf_data1 = regs[in_rs1];
  assign rf_data2 = regs[in_rs2];

  always #5 clk = ~clk;

  id_ex_operand_stage #(.CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_ctrl(in_ctrl),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_fwd1(out_fwd1), .out_fwd2(out_fwd2),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_ctrl(out_ctrl)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: contents of the output register (A) and the history slot (B).
  bit          m_valid, m_rw, m_mr;
  logic [63:0] m_op1, m_op2;
  logic [1:0]  m_f1, m_f2;
  logic [4:0]  m_rd;
  logic [CW-1:0] m_ctrl;
  bit          h_valid, h_rw;
  logic [4:0]  h_rd;

  logic [63:0] e_op1, e_op2;
  logic [1:0]  e_f1, e_f2;
  bit          e_rdy;

  typedef struct {
    bit          v;
    bit          w;
    logic [4:0]  rd;
    bit          ld;
    logic [63:0] data;
  } prod_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Walk the producers youngest-first; the first one that writes rs decides the outcome.
  function automatic void resolve(input logic [4:0] rs, output logic [63:0] op,
                                  output logic [1:0] tag, output bit hz);
    prod_t p [4];
    bit found = 1'b0;
    p[0] = '{m_valid, m_rw, m_rd, m_mr, 64'd0};
    p[1] = '{h_valid, h_rw, h_rd, 1'b0, 64'd0};
    p[2] = '{mem_fwd_valid, 1'b1, mem_fwd_rd, 1'b0, mem_fwd_data};
    p[3] = '{wb_valid, 1'b1, wb_rd, 1'b0, wb_data};
    op  = regs[rs];
    tag = FWD_NONE;
    hz  = 1'b0;
    if (rs == 5'd31) begin
      op = 64'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!found && p[k].v && p[k].w && p[k].rd == rs) begin
          found = 1'b1;
          case (k)
            0: if (p[k].ld) hz = 1'b1; else tag = FWD_EXMEM;
            1: tag = FWD_MEMWB;
            2: op = p[k].data;
            default: begin
`ifdef WB_BYPASS_EN
              op = p[k].data;
`else
              hz = 1'b1;
`endif
            end
          endcase
        end
      end
    end
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_op1 = '0; m_op2 = '0;
    m_f1 = FWD_NONE; m_f2 = FWD_NONE; m_rd = '0; m_ctrl = '0;
    h_valid = 0; h_rw = 0; h_rd = '0;
  endtask

  task automatic model_comb();
    bit hz1, hz2;
    resolve(in_rs1, e_op1, e_f1, hz1);
    resolve(in_rs2, e_op2, e_f2, hz2);
    e_rdy = (!m_valid || out_ready) && !(hz1 || hz2);
  endtask

  task automatic model_seq();
    bit acc;
    acc = in_valid && e_rdy && !flush;
    if (out_ready) begin
      h_valid = m_valid; h_rd = m_rd; h_rw = m_rw;
    end
    if (wb_valid && wb_rd != 5'd31) regs[wb_rd] = wb_data;
    if (flush) m_valid = 0;
    else if (acc) m_valid = 1;
    else if (out_ready) m_valid = 0;
    if (acc) begin
      m_op1 = e_op1; m_op2 = e_op2; m_f1 = e_f1; m_f2 = e_f2;
      m_rd = in_rd; m_rw = in_reg_write; m_mr = in_mem_read; m_ctrl = in_ctrl;
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_op1", out_op1, m_op1);
    chk("out_op2", out_op2, m_op2);
    chk("out_fwd1", 64'(out_fwd1), 64'(m_f1));
    chk("out_fwd2", 64'(out_fwd2), 64'(m_f2));
    chk("out_rd", 64'(out_rd), 64'(m_rd));
    chk("out_reg_write", 64'(out_reg_write), 64'(m_rw));
    chk("out_mem_read", 64'(out_mem_read), 64'(m_mr));
    chk("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
  endtask

  // Inputs are already set at posedge+1; check in_ready, clock, then check outputs.
  task automatic cycle();
    #2;
    model_comb();
    chk("in_ready", 64'(in_ready), 64'(e_rdy));
    @(posedge clk);
    #1;
    model_seq();
    check_outputs();
  endtask

  task automatic peek_ready(input string tag, input bit exp);
    #1;
    chk(tag, 64'(in_ready), 64'(exp));
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_reg_write = 0; in_mem_read = 0; in_ctrl = '0;
    mem_fwd_valid = 0; mem_fwd_rd = 5'd0; mem_fwd_data = '0;
    wb_valid = 0; wb_rd = 5'd0; wb_data = '0;
  endtask

  task automatic drain();
    idle();
    cycle();
    cycle();
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input bit rw, input bit mr);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_reg_write = rw; in_mem_read = mr; in_ctrl = CW'($urandom);
  endtask

  function automatic logic [4:0] pick();
    int unsigned r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    check_outputs();
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back ALU dependency forwards from EX/MEM with no stall.
    issue(5'd0, 5'd0, 5'd1, 1, 0);
    cycle();
    issue(5'd1, 5'd0, 5'd4, 1, 0);
    peek_ready("alu_no_stall", 1);
    cycle();
    chk("alu_fwd1", 64'(out_fwd1), 64'(FWD_EXMEM));

    // Load-use: one stall, one bubble, then MEM/WB tag.
    drain();
    issue(5'd0, 5'd0, 5'd2, 1, 1);
    cycle();
    issue(5'd0, 5'd2, 5'd6, 1, 0);
    peek_ready("lu_stall", 0);
    cycle();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    peek_ready("lu_resume", 1);
    cycle();
    chk("lu_valid", 64'(out_valid), 64'd1);
    chk("lu_fwd2", 64'(out_fwd2), 64'(FWD_MEMWB));

    // MEM port value bypass.
    drain();
    issue(5'd0, 5'd3, 5'd7, 0, 0);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 64'hDEAD;
    cycle();
    chk("mem_op2", out_op2, 64'hDEAD);
    chk("mem_fwd2", 64'(out_fwd2), 64'(FWD_NONE));

    // Every producer writing X31 must not disturb a read of X31.
    drain();
    issue(5'd0, 5'd0, 5'd31, 1, 0);
    cycle();
    issue(5'd0, 5'd0, 5'd31, 1, 0);
    cycle();
    issue(5'd31, 5'd31, 5'd8, 1, 0);
    mem_fwd_valid = 1; mem_fwd_rd = 5'd31; mem_fwd_data = 64'hDEAD;
    wb_valid = 1; wb_rd = 5'd31; wb_data = 64'h55;
    cycle();
    chk("xzr_op2", out_op2, 64'd0);
    chk("xzr_fwd2", 64'(out_fwd2), 64'(FWD_NONE));

    // WB port: bypass or one stall depending on build.
    drain();
    issue(5'd5, 5'd0, 5'd8, 1, 0);
    wb_valid = 1; wb_rd = 5'd5; wb_data = 64'h55;
`ifdef WB_BYPASS_EN
    peek_ready("wb_no_stall", 1);
    cycle();
`else
    peek_ready("wb_stall", 0);
    cycle();
    wb_valid = 0;
    peek_ready("wb_resume", 1);
    cycle();
`endif
    chk("wb_op1", out_op1, 64'h55);

    // Back-pressure holds the output register; then flush drops it.
    drain();
    issue(5'd0, 5'd0, 5'd9, 1, 0);
    cycle();
    out_ready = 0;
    issue(5'd0, 5'd0, 5'd10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      peek_ready("bp_ready", 0);
      cycle();
      chk("bp_rd", 64'(out_rd), 64'd9);
    end
    out_ready = 1;
    flush = 1;
    cycle();
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush = 0;

    // Async reset while a load-use is pending.
    drain();
    issue(5'd0, 5'd0, 5'd2, 1, 1);
    cycle();
    out_ready = 0;
    issue(5'd2, 5'd0, 5'd11, 1, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_valid      = ($urandom % 4) != 0;
      in_rs1        = pick();
      in_rs2        = pick();
      in_rd         = pick();
      in_reg_write  = ($urandom % 4) != 0;
      in_mem_read   = ($urandom % 3) == 0;
      in_ctrl       = CW'($urandom);
      out_ready     = ($urandom % 4) != 0;
      flush         = ($urandom % 16) == 0;
      mem_fwd_valid = ($urandom % 2) != 0;
      mem_fwd_rd    = pick();
      mem_fwd_data  = {$urandom, $urandom};
      wb_valid      = ($urandom % 2) != 0;
      wb_rd         = pick();
      wb_data       = {$urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX operand stage sitting directly downstream of the 64-bit, 32-entry register file (X31 = XZR, always zero).
- Consumes the two register-file read ports plus decoded control.
- Resolves data hazards: value bypass from MEM and WB, forwarding tags for the two youngest producers, and a one-bubble load-use stall.
- Registers the resolved operands toward EX behind a valid/ready handshake.

## Interface
Parameters:
- CTRL_W, 16: width of opaque decoded control passed through to EX.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  kill the instruction being captured and the one held in the output register
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs1, in_rs2  in  5  source register numbers; also drive the register file read selects
- in_rd  in  5  destination register
- in_reg_write, in_mem_read  in  1  instruction writes a register / is a load
- in_ctrl  in  CTRL_W  pass-through control
- rf_data1, rf_data2  in  64  register-file read data for in_rs1/in_rs2
- mem_fwd_valid, mem_fwd_rd, mem_fwd_data  in  1/5/64  instruction in MEM: writes mem_fwd_rd with mem_fwd_data (ALU result or load data)
- wb_valid, wb_rd, wb_data  in  1/5/64  register-file write this edge (same signals as the regfile write port)
- out_valid  out  1  EX holds a valid instruction
- out_ready  in  1  EX accepts this cycle
- out_op1, out_op2  out  64  resolved operands
- out_fwd1, out_fwd2  out  2  fwd_sel_e: EX overrides the operand with its EX/MEM or MEM/WB result
- out_rd, out_reg_write, out_mem_read, out_ctrl  out  5/1/1/CTRL_W  registered copies

## Operation
- Naming of the three instructions ahead of the one being captured:
  - A = the instruction in the output register.
  - B = history register holding the instruction last handed to EX (valid, rd, reg_write).
  - C = the MEM port (mem_fwd_*); D = the WB port (wb_*).
- Match rule: a producer matches a source only if it is valid, writes a register, its rd equals the source, and the source is not 31. rs = 31 always yields 0 with tag FWD_NONE.
- Per-operand priority: A > B > C > D > rf_data.
  - A match, non-load: tag FWD_EXMEM, op = rf_data (don't-care).
  - A match, load: load-use hazard; in_ready = 0.
  - B match: tag FWD_MEMWB.
  - C match: op = mem_fwd_data.
  - D match: see Configuration.
  - No match: op = rf_data.
- in_ready = (!out_valid || out_ready) && !hazard.
- Accept = in_valid && in_ready && !flush; on accept, the output register loads the resolved operands, tags and control.
- On out fire (out_valid && out_ready) without accept, out_valid clears: a bubble is inserted.
- History register update:
  - On out_ready high, history loads A (valid = out_valid).
  - On out_ready low, history holds.
- flush clears out_valid and blocks capture in the same cycle. History is unaffected.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Load-use costs exactly 1 bubble: the load moves to B and the dependent instruction is captured with FWD_MEMWB.
- All hazard and forward decisions are combinational in the accept cycle.
- Reset state: out_valid=0, out_op1/2=0, out_fwd1/2=FWD_NONE, out_rd=0, out_reg_write=0, out_mem_read=0, out_ctrl=0, history invalid.
- Reset asserted mid-operation drops in-flight state immediately. in_ready follows combinationally.
- Outputs are held stable while out_valid && !out_ready.

## Configuration
- WB_BYPASS_EN
  - Defined: a D match selects wb_data (same-edge write bypass).
  - Undefined: a D match (with no higher-priority match) is a hazard. in_ready = 0 for one cycle, then the register file supplies the written value.

## Structure
- cpu_pkg holds:
  - XZR = 5'd31
  - fwd_sel_e {FWD_NONE=0, FWD_EXMEM=1, FWD_MEMWB=2}
  - CTRL_W default
- Sub-module operand_fwd_mux: combinational per-operand priority select that returns op, tag and hazard. Instantiated twice.

## Test plan
- ADD X1 followed by SUB using X1: second instruction captured with out_fwd1=FWD_EXMEM and no stall.
- LDUR X2 followed by ADD using X2: in_ready=0 for exactly 1 cycle, one bubble on out_valid, then capture with FWD_MEMWB.
- mem_fwd_rd=3, data 0xDEAD with rf_data=0 and rs2=3: out_op2=0xDEAD. Same with rs2=31 and all producers writing 31: out_op2=0, FWD_NONE.
- wb_rd=5, wb_data=0x55, rs1=5: with WB_BYPASS_EN, out_op1=0x55 with no stall; without it, 1 stall cycle then out_op1 = regfile value 0x55.
- out_ready low for 3 cycles while in_valid high: outputs stable, in_ready=0, no capture. flush pulse: out_valid=0 next cycle.
- rst_n asserted while out_valid=1 with a pending load-use: all outputs return to reset values immediately and in_ready=1.
